// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-in-ID hazard controller with a programmable-length stall counter,
// memory-busy freeze, taken-branch IF/ID flush and a saturating stall-event counter.
module hazard_stall_ctrl #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned BR_IN_ID = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             ifid_branch,
    input  logic             br_taken,
    input  logic             idex_mem_read,
    input  logic             idex_reg_write,
    input  logic [REG_W-1:0] idex_dst,
    input  logic             exmem_mem_read,
    input  logic [REG_W-1:0] exmem_dst,
    input  logic             mem_busy,
    output logic             pc_wr,
    output logic             ifid_wr,
    output logic             id_bubble,
    output logic             ifid_flush,
    output logic             pipe_freeze,
    output logic [2:0]       stall_cnt,
    output logic [CNT_W-1:0] stall_events
);

    localparam logic [3:0] LatN   = 4'(MEM_LAT);
    localparam logic [3:0] LatP1  = 4'(MEM_LAT + 1);
    localparam bit         BrInId = (BR_IN_ID != 0);

    logic             match_ex;
    logic             match_mem;
    logic [3:0]       need;
    logic             stalling;
    logic [2:0]       cnt_d, cnt_q;
    logic [CNT_W-1:0] ev_d, ev_q;

    // Register 0 is hard-wired, so it never creates a dependency.
    assign match_ex  = (idex_dst != '0) &&
                       ((idex_dst == ifid_rs) || (ifid_uses_rt && (idex_dst == ifid_rt)));
    assign match_mem = (exmem_dst != '0) &&
                       ((exmem_dst == ifid_rs) || (ifid_uses_rt && (exmem_dst == ifid_rt)));

    always_comb begin
        need = '0;
        if (idex_mem_read && match_ex) begin
            need = LatN;
        end
        if (BrInId && ifid_branch) begin
            if (idex_reg_write && !idex_mem_read && match_ex && (need < 4'd1)) begin
                need = 4'd1;
            end
            if (idex_mem_read && match_ex) begin
                need = LatP1;
            end
            if (exmem_mem_read && match_mem && (need < LatN)) begin
                need = LatN;
            end
        end
    end

    // An active countdown ignores fresh detection until it expires.
    assign stalling = (cnt_q != 3'd0) || (need != 4'd0);

    always_comb begin
        pc_wr       = 1'b0;
        ifid_wr     = 1'b0;
        id_bubble   = 1'b0;
        ifid_flush  = 1'b0;
        pipe_freeze = 1'b0;
        if (!rst_n) begin
            id_bubble = 1'b1;
        end else if (mem_busy) begin
            pipe_freeze = 1'b1;
        end else if (stalling) begin
            id_bubble = 1'b1;
        end else begin
            pc_wr      = 1'b1;
            ifid_wr    = 1'b1;
            ifid_flush = ifid_branch && br_taken;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!mem_busy) begin
            if (cnt_q != 3'd0) begin
                cnt_d = cnt_q - 3'd1;
            end else if (need != 4'd0) begin
                cnt_d = 3'(need - 4'd1);
            end
        end
    end

    always_comb begin
        ev_d = ev_q;
        if (id_bubble && (ev_q != '1)) begin
            ev_d = ev_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ev_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            ev_q  <= ev_d;
        end
    end

    assign stall_cnt    = cnt_q;
    assign stall_events = ev_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances (MEM_LAT=1, MEM_LAT=3, CNT_W=2)
// share one stimulus stream; each phase starts from reset and checks one instance.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ifid_rs, ifid_rt, idex_dst, exmem_dst;
    logic       ifid_uses_rt, ifid_branch, br_taken;
    logic       idex_mem_read, idex_reg_write, exmem_mem_read, mem_busy;

    logic        a_pc, a_ifwr, a_bub, a_fl, a_fr;
    logic [2:0]  a_cnt;
    logic [15:0] a_ev;
    logic        b_pc, b_ifwr, b_bub, b_fl, b_fr;
    logic [2:0]  b_cnt;
    logic [15:0] b_ev;
    logic        c_pc, c_ifwr, c_bub, c_fl, c_fr;
    logic [2:0]  c_cnt;
    logic [1:0]  c_ev;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [7:0] VIdle  = 8'b1100_0000;
    localparam logic [7:0] VFlush = 8'b1101_0000;
    localparam logic [7:0] VReset = 8'b0010_0000;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_LAT(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .ifid_branch(ifid_branch), .br_taken(br_taken),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_dst(idex_dst),
        .exmem_mem_read(exmem_mem_read), .exmem_dst(exmem_dst), .mem_busy(mem_busy),
        .pc_wr(a_pc), .ifid_wr(a_ifwr), .id_bubble(a_bub), .ifid_flush(a_fl),
        .pipe_freeze(a_fr), .stall_cnt(a_cnt), .stall_events(a_ev)
    );

    hazard_stall_ctrl #(.MEM_LAT(3), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .ifid_branch(ifid_branch), .br_taken(br_taken),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_dst(idex_dst),
        .exmem_mem_read(exmem_mem_read), .exmem_dst(exmem_dst), .mem_busy(mem_busy),
        .pc_wr(b_pc), .ifid_wr(b_ifwr), .id_bubble(b_bub), .ifid_flush(b_fl),
        .pipe_freeze(b_fr), .stall_cnt(b_cnt), .stall_events(b_ev)
    );

    hazard_stall_ctrl #(.MEM_LAT(1), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .ifid_branch(ifid_branch), .br_taken(br_taken),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_dst(idex_dst),
        .exmem_mem_read(exmem_mem_read), .exmem_dst(exmem_dst), .mem_busy(mem_busy),
        .pc_wr(c_pc), .ifid_wr(c_ifwr), .id_bubble(c_bub), .ifid_flush(c_fl),
        .pipe_freeze(c_fr), .stall_cnt(c_cnt), .stall_events(c_ev)
    );

    function automatic logic [7:0] v_stall(input logic [2:0] c);
        return {5'b00100, c};
    endfunction

    function automatic logic [7:0] v_freeze(input logic [2:0] c);
        return {5'b00001, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: change inputs after the falling edge, settle, then the caller checks.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic br, input logic tk, input logic exr, input logic exw,
                         input logic [4:0] exd, input logic mr, input logic [4:0] md,
                         input logic busy);
        @(negedge clk);
        ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = urt; ifid_branch = br; br_taken = tk;
        idex_mem_read = exr; idex_reg_write = exw; idex_dst = exd;
        exmem_mem_read = mr; exmem_dst = md; mem_busy = busy;
        #1;
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst_n = 1'b0;
        ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0; ifid_branch = 1'b0; br_taken = 1'b0;
        idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_dst = '0;
        exmem_mem_read = 1'b0; exmem_dst = '0; mem_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0; ifid_branch = 1'b0; br_taken = 1'b0;
        idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_dst = '0;
        exmem_mem_read = 1'b0; exmem_dst = '0; mem_busy = 1'b0;
        #12;
        chk("reset_outputs", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, VReset);
        chk("reset_events", a_ev, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use with MEM_LAT=1: one bubble, then release
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        chk("lu_stall", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, v_stall(0));
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_release", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, VIdle);
        chk("lu_events", a_ev, 1);

        // Register 0, non-matching regs, unused rt
        drive(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        chk("zero_reg", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, VIdle);
        drive(4, 5, 1, 0, 0, 1, 1, 1, 0, 0, 0);
        chk("no_match", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, VIdle);
        drive(4, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        chk("rt_unused", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, VIdle);
        drive(4, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0);
        chk("rt_used", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, v_stall(0));
        drive(4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rt_events", a_ev, 2);

        // Branches in ID
        drive(3, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("br_flush", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, VFlush);
        drive(3, 4, 1, 1, 1, 0, 1, 3, 0, 0, 0);
        chk("br_alu_stall", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, v_stall(0));
        drive(3, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("br_alu_flush", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, VFlush);
        drive(3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("br_not_taken", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, VIdle);
        drive(3, 4, 1, 0, 0, 0, 1, 3, 0, 0, 0);
        chk("alu_no_branch", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, VIdle);
        drive(0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        chk("br_zero_reg", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, VFlush);
        drive(3, 4, 1, 1, 1, 0, 0, 0, 1, 4, 0);
        chk("br_mem_load", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, v_stall(0));
        drive(3, 4, 1, 1, 1, 1, 1, 3, 0, 0, 0);
        chk("br_ex_load0", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, v_stall(0));
        drive(3, 4, 1, 1, 1, 1, 1, 3, 0, 0, 0);
        chk("br_ex_load1", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, v_stall(1));
        drive(3, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("br_ex_load_flush", {a_pc, a_ifwr, a_bub, a_fl, a_fr, a_cnt}, VFlush);
        chk("br_events", a_ev, 6);

        // MEM_LAT=3: beq behind lw needs four bubbles
        reset_all();
        drive(2, 0, 1, 1, 1, 1, 1, 2, 0, 0, 0);
        chk("lat3_c0", {b_pc, b_ifwr, b_bub, b_fl, b_fr, b_cnt}, v_stall(0));
        drive(2, 0, 1, 1, 1, 1, 1, 2, 0, 0, 0);
        chk("lat3_c1", {b_pc, b_ifwr, b_bub, b_fl, b_fr, b_cnt}, v_stall(3));
        drive(2, 0, 1, 1, 1, 0, 0, 0, 1, 2, 0);
        chk("lat3_c2", {b_pc, b_ifwr, b_bub, b_fl, b_fr, b_cnt}, v_stall(2));
        drive(2, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("lat3_c3", {b_pc, b_ifwr, b_bub, b_fl, b_fr, b_cnt}, v_stall(1));
        drive(2, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("lat3_flush", {b_pc, b_ifwr, b_bub, b_fl, b_fr, b_cnt}, VFlush);
        chk("lat3_events", b_ev, 4);

        // Memory-busy freeze mid-stall, then asynchronous reset mid-stall
        reset_all();
        drive(2, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0);
        chk("frz_start", {b_pc, b_ifwr, b_bub, b_fl, b_fr, b_cnt}, v_stall(0));
        drive(2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1);
        chk("frz_0", {b_pc, b_ifwr, b_bub, b_fl, b_fr, b_cnt}, v_freeze(2));
        drive(2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1);
        chk("frz_1", {b_pc, b_ifwr, b_bub, b_fl, b_fr, b_cnt}, v_freeze(2));
        chk("frz_events", b_ev, 1);
        drive(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("frz_resume", {b_pc, b_ifwr, b_bub, b_fl, b_fr, b_cnt}, v_stall(2));
        chk("frz_resume_events", b_ev, 1);
        drive(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("frz_cnt1", b_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {b_pc, b_ifwr, b_bub, b_fl, b_fr, b_cnt}, VReset);
        chk("async_rst_events", b_ev, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // CNT_W=2: event counter saturates at 3
        reset_all();
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        chk("sat_stall", {c_pc, c_ifwr, c_bub, c_fl, c_fr, c_cnt}, v_stall(0));
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        chk("sat_ev2", c_ev, 2);
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        chk("sat_ev3", c_ev, 3);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_hold", c_ev, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
